pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 130 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset/lock supervisor with staged downstream reset release.
module pll_reset_sequencer #(
  parameter int NUM_RESETS     = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_STABLE    = 1024,
  parameter int STAGE_GAP      = 64,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [NUM_RESETS-1:0] rst_out,
  output logic                  ready,
  output logic [CNT_W-1:0]      lock_loss_count,
  output logic [CNT_W-1:0]      retry_count,
  output logic [2:0]            state_dbg
);
  localparam int M1 = LOCK_TIMEOUT > LOCK_STABLE ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int MC = M1 > PLL_RST_CYCLES ? M1 : PLL_RST_CYCLES;
  localparam int CW = $clog2(MC);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int IW = $clog2(NUM_RESETS + 1);
  localparam logic [CNT_W-1:0] SAT = '1;
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;
  state_t state, state_n;
  logic ls1, lock_s, ready_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [GW-1:0] gap, gap_n;
  logic [IW-1:0] idx, idx_n;
  logic [NUM_RESETS-1:0] rst_out_n;
  logic [CNT_W-1:0] loss_n, retry_n;
  assign state_dbg = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      ls1             <= 1'b0;
      lock_s          <= 1'b0;
      state           <= RESET_PLL;
      cnt             <= '0;
      gap             <= '0;
      idx             <= '0;
      pll_rst         <= 1'b1;
      rst_out         <= '1;
      ready           <= 1'b0;
      lock_loss_count <= '0;
      retry_count     <= '0;
    end else begin
      ls1             <= pll_locked;
      lock_s          <= ls1;
      state           <= state_n;
      cnt             <= cnt_n;
      gap             <= gap_n;
      idx             <= idx_n;
      pll_rst         <= state_n == RESET_PLL;
      rst_out         <= rst_out_n;
      ready           <= ready_n;
      lock_loss_count <= loss_n;
      retry_count     <= retry_n;
    end
  end
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    gap_n     = gap;
    idx_n     = idx;
    rst_out_n = rst_out;
    ready_n   = ready;
    loss_n    = lock_loss_count;
    retry_n   = retry_count;
    case (state)
      RESET_PLL: begin
        state_n = cnt == CW'(PLL_RST_CYCLES - 1) ? WAIT_LOCK : RESET_PLL;
        cnt_n   = cnt == CW'(PLL_RST_CYCLES - 1) ? '0 : cnt + 1'b1;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_n = STABILIZE;
          cnt_n   = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          state_n = RESET_PLL;
          cnt_n   = '0;
          retry_n = retry_count == SAT ? retry_count : retry_count + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == CW'(LOCK_STABLE - 1)) begin
          state_n = RELEASE;
          cnt_n   = '0;
          idx_n   = '0;
          gap_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (gap == GW'(STAGE_GAP - 1)) begin
          rst_out_n = rst_out & ~(NUM_RESETS'(1) << idx);
          idx_n     = idx + 1'b1;
          gap_n     = '0;
          state_n   = idx == IW'(NUM_RESETS - 1) ? RUN : RELEASE;
          ready_n   = idx == IW'(NUM_RESETS - 1);
        end else begin
          gap_n = gap + 1'b1;
        end
      end
      RUN: ;
      default: state_n = RESET_PLL;
    endcase
    // lock loss overrides any release scheduled this cycle; the PLL relocks on its own
    if ((state == RELEASE || state == RUN) && !lock_s) begin
      state_n   = WAIT_LOCK;
      cnt_n     = '0;
      rst_out_n = '1;
      ready_n   = 1'b0;
      loss_n    = lock_loss_count == SAT ? lock_loss_count : lock_loss_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed and random checks against a phase/elapsed-time model.
module tb_pll_reset_sequencer;
  localparam int NR = 3, PRC = 4, LTO = 20, LST = 8, GAP = 3;
  localparam logic [NR-1:0] ONES = '1;
  logic clk = 1'b0, rst = 1'b1, pll_locked = 1'b0;
  logic pll_rst, ready, s_pll_rst, s_ready;
  logic [NR-1:0] rst_out, s_rst_out;
  logic [7:0] lock_loss_count, retry_count;
  logic [1:0] s_loss, s_retry;
  logic [2:0] state_dbg, s_state;
  int total = 0, passed = 0, failed = 0;
  int m_phase, m_t, m_loss, m_retry;
  bit m_ls1, m_ls;
  logic [NR-1:0] seq[$];
  int prs = 0;
  always #5 clk = ~clk;
  pll_reset_sequencer #(.NUM_RESETS(NR), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTO),
    .LOCK_STABLE(LST), .STAGE_GAP(GAP), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst), .rst_out(rst_out),
    .ready(ready), .lock_loss_count(lock_loss_count), .retry_count(retry_count),
    .state_dbg(state_dbg));
  pll_reset_sequencer #(.NUM_RESETS(NR), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTO),
    .LOCK_STABLE(LST), .STAGE_GAP(GAP), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .pll_rst(s_pll_rst), .rst_out(s_rst_out),
    .ready(s_ready), .lock_loss_count(s_loss), .retry_count(s_retry), .state_dbg(s_state));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask
  // phases: 0 PLL reset, 1 wait lock, 2 stabilize, 3 release, 4 run; m_t = cycles spent in phase
  task automatic model_step();
    bit loss;
    loss = 0;
    if (rst) begin
      m_phase = 0; m_t = 0; m_loss = 0; m_retry = 0; m_ls1 = 0; m_ls = 0;
    end else begin
      case (m_phase)
        0: if (m_t + 1 == PRC) begin m_phase = 1; m_t = 0; end else m_t++;
        1: if (m_ls) begin m_phase = 2; m_t = 0; end
           else if (m_t + 1 == LTO) begin m_phase = 0; m_t = 0; m_retry++; end
           else m_t++;
        2: if (!m_ls) begin m_phase = 1; m_t = 0; end
           else if (m_t + 1 == LST) begin m_phase = 3; m_t = 0; end
           else m_t++;
        3: if (!m_ls) loss = 1; else begin m_t++; if (m_t == NR * GAP) m_phase = 4; end
        default: if (!m_ls) loss = 1;
      endcase
      if (loss) begin m_phase = 1; m_t = 0; m_loss++; end
      m_ls = m_ls1;
      m_ls1 = pll_locked;
    end
  endtask
  task automatic check_model();
    logic [NR-1:0] eo;
    eo = m_phase == 3 ? ONES << (m_t / GAP) : (m_phase == 4 ? '0 : ONES);
    chk("pll_rst", pll_rst, m_phase == 0);
    chk("rst_out", rst_out, eo);
    chk("ready", ready, m_phase == 4);
    chk("state_dbg", state_dbg, m_phase);
    chk("lock_loss_count", lock_loss_count, m_loss > 255 ? 255 : m_loss);
    chk("retry_count", retry_count, m_retry > 255 ? 255 : m_retry);
    chk("sat_rst_out", s_rst_out, eo);
    chk("sat_loss", s_loss, m_loss > 3 ? 3 : m_loss);
    chk("sat_retry", s_retry, m_retry > 3 ? 3 : m_retry);
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
    if (seq.size() == 0 || seq[$] !== rst_out) seq.push_back(rst_out);
    if (pll_rst) prs++;
  endtask
  task automatic wait_ready(input int budget, output int n);
    seq.delete();
    seq.push_back(rst_out);
    n = 0;
    while (ready !== 1'b1 && n < budget) begin tick(); n++; end
  endtask
  task automatic check_seq(input string tag);
    logic [NR-1:0] w;
    chk({tag, "_len"}, seq.size(), NR + 1);
    for (int i = 0; i < seq.size() && i <= NR; i++) begin
      w = ONES << i;
      chk($sformatf("%s_%0d", tag, i), seq[i], w);
    end
  endtask
  task automatic check_reset_values(input string tag);
    chk({tag, "_pll_rst"}, pll_rst, 1);
    chk({tag, "_rst_out"}, rst_out, 7);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_loss"}, lock_loss_count, 0);
    chk({tag, "_retry"}, retry_count, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask
  initial begin
    int n, hold;
    rst = 1; pll_locked = 0;
    tick(); tick();
    check_reset_values("reset");
    // nominal bring-up
    rst = 0;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin tick(); n++; end
    chk("pll_rst_width", n, PRC);
    repeat (5) tick();
    pll_locked = 1;
    wait_ready(100, n);
    chk("nominal_ready", ready, 1);
    chk("nominal_latency", n, 20);
    check_seq("nominal_seq");
    chk("nominal_loss", lock_loss_count, 0);
    chk("nominal_retry", retry_count, 0);
    // loss in RUN
    pll_locked = 0;
    tick(); tick();
    chk("run_loss_pending_ready", ready, 1);
    tick();
    chk("run_loss_rst_out", rst_out, 7);
    chk("run_loss_ready", ready, 0);
    chk("run_loss_count", lock_loss_count, 1);
    chk("run_loss_state", state_dbg, 1);
    pll_locked = 1;
    prs = 0;
    wait_ready(100, n);
    chk("relock_ready", ready, 1);
    chk("relock_no_pll_rst", prs, 0);
    check_seq("relock_seq");
    // loss mid-RELEASE: lock_s goes low exactly on the edge the second release is due
    pll_locked = 0;
    repeat (3) tick();
    pll_locked = 1;
    n = 0;
    while (rst_out !== 3'b110 && n < 60) begin tick(); n++; end
    chk("mid_reached_110", rst_out, 3'b110);
    pll_locked = 0;
    tick();
    chk("mid_hold1", rst_out, 3'b110);
    tick();
    chk("mid_hold2", rst_out, 3'b110);
    tick();
    chk("mid_rst_out", rst_out, 7);
    chk("mid_loss_count", lock_loss_count, 3);
    chk("mid_state", state_dbg, 1);
    pll_locked = 1;
    wait_ready(100, n);
    chk("mid_recover_ready", ready, 1);
    // unstable lock
    rst = 1; pll_locked = 0;
    tick();
    rst = 0;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin tick(); n++; end
    prs = 0;
    pll_locked = 1;
    repeat (5) tick();
    pll_locked = 0;
    tick();
    pll_locked = 1;
    wait_ready(100, n);
    chk("unstable_ready", ready, 1);
    chk("unstable_latency", n, 20);
    chk("unstable_loss", lock_loss_count, 0);
    chk("unstable_no_pll_rst", prs, 0);
    // timeout retry and saturation
    rst = 1; pll_locked = 0;
    tick();
    rst = 0;
    for (int k = 1; k <= 5; k++) begin
      repeat (PRC + LTO) tick();
      chk($sformatf("retry_%0d", k), retry_count, k);
      chk($sformatf("sat_retry_%0d", k), s_retry, k > 3 ? 3 : k);
      chk($sformatf("retry_pll_rst_%0d", k), pll_rst, 1);
      chk($sformatf("retry_rst_out_%0d", k), rst_out, 7);
    end
    // reset override in RUN
    pll_locked = 1;
    wait_ready(200, n);
    chk("override_pre_ready", ready, 1);
    rst = 1;
    tick();
    check_reset_values("override");
    chk("override_sat_retry", s_retry, 0);
    rst = 0;
    // randomized lock behaviour with occasional reset
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        pll_locked = $urandom_range(0, 3) != 0;
        hold = $urandom_range(1, 40);
      end
      hold--;
      rst = $urandom_range(0, 499) == 0;
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
